lut_prog: RTL

Programmable, registered lookup table: the parametrised successor to the fixed immediate/target LUT. It holds DEPTH entries of WIDTH bits and self-initialises after reset to the standard constant set (one-hot powers of two, then zero, then all-ones). Software-visible writes let the control path retarget entries at run time. It sits beside the decoder, mapping a short instruction field to a wide immediate or branch target with one cycle of read latency.

---
 rtl/lut_prog.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lut_prog.sv
// ---------------------------------------------------------------------------
// lut_prog: programmable registered lookup table, DEPTH entries of WIDTH bits.
// Self-initialises after reset to the standard constant set:
//   entry k < WIDTH  -> 1 << k
//   entry k == WIDTH -> 0
//   entry k > WIDTH  -> all ones
// After initialisation, reads return data one cycle later, fully pipelined.
// Run-time writes retarget entries.
//
// Build option:
//   LUT_BYPASS_EN  defined   -> a same-edge read and write to one in-range
//                               address returns WrData (write-first)
//                  undefined -> that read returns the old entry (read-first)
//
// Ports:
//   Clk      in   clock; all state changes on its rising edge
//   Reset    in   synchronous active-high reset; restarts initialisation
//   RdEn     in   read request
//   RdAddr   in   [AW]    read index
//   RdData   out  [WIDTH] registered read data; holds when there is no read
//   RdValid  out  RdData was updated by a read this cycle
//   WrEn     in   write request
//   WrAddr   in   [AW]    write index
//   WrData   in   [WIDTH] write data
//   Busy     out  initialisation in progress; requests are ignored
// ---------------------------------------------------------------------------
module lut_prog #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             RdEn,
    input  logic [AW-1:0]    RdAddr,
    output logic [WIDTH-1:0] RdData,
    output logic             RdValid,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    // Default content for a given entry index.
    function automatic logic [WIDTH-1:0] default_entry(input logic [AW-1:0] idx);
        int unsigned k;
        k = 32'(idx);
        if (k < WIDTH) begin
            return WIDTH'(1) << k;
        end else if (k == WIDTH) begin
            return '0;
        end else begin
            return '1;
        end
    endfunction

    state_e           state_q,    state_d;
    logic [AW-1:0]    init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0] rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             busy_q,     busy_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             mem_we_c;
    logic [AW-1:0]    mem_waddr_c;
    logic [WIDTH-1:0] mem_wdata_c;
    logic             rd_in_range_c;
    logic             wr_in_range_c;
    logic [AW-1:0]    rd_idx_c;

    // Address range checks; only matter when DEPTH is not a power of two.
    always_comb begin
        rd_in_range_c = (32'(RdAddr) < DEPTH);
        wr_in_range_c = (32'(WrAddr) < DEPTH);
        rd_idx_c      = rd_in_range_c ? RdAddr : '0;
    end

    // Next-state, table write port and read pipeline.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = '0;
        mem_wdata_c = '0;

        case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = init_cnt_q;
                mem_wdata_c = default_entry(init_cnt_q);
                if (init_cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end else begin
                    init_cnt_d = init_cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                // Out-of-range writes are dropped.
                if (WrEn && wr_in_range_c) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = WrAddr;
                    mem_wdata_c = WrData;
                end
                if (RdEn) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_in_range_c ? mem_q[rd_idx_c] : '0;
`ifdef LUT_BYPASS_EN
                    // Write-first: forward the same-edge write data.
                    if (WrEn && wr_in_range_c && (WrAddr == RdAddr)) begin
                        rd_data_d = WrData;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A reset edge writes nothing; initialisation rebuilds every entry.
        if (Reset) begin
            mem_we_c = 1'b0;
        end

        busy_d = (state_d == ST_INIT);
    end

    // Control and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Table storage; contents are rebuilt by initialisation, so no reset.
    always_ff @(posedge Clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
    assign Busy    = busy_q;

endmodule
